// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops plus iterative shift-add multiply and restoring divide.
// Define ALU_EXEC_HIWORD_EN to add result_hi (product high word / division remainder).
module alu_exec_unit #(
    parameter int unsigned n = 32,
    parameter int unsigned l = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [l-1:0] ALU_Control,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result,
    output logic         zero,
    output logic         error
`ifdef ALU_EXEC_HIWORD_EN
    ,
    output logic [n-1:0] result_hi
`endif
);

    localparam int unsigned CW = $clog2(n);
`ifdef ALU_EXEC_HIWORD_EN
    localparam int unsigned PW = 2 * n;
`else
    localparam int unsigned PW = n;
`endif

    localparam logic [l-1:0] OP_ADD  = l'(4'h1);
    localparam logic [l-1:0] OP_SUB  = l'(4'h2);
    localparam logic [l-1:0] OP_ADDI = l'(4'h3);
    localparam logic [l-1:0] OP_SUBI = l'(4'h4);
    localparam logic [l-1:0] OP_MUL  = l'(4'h5);
    localparam logic [l-1:0] OP_DIV  = l'(4'h6);
    localparam logic [l-1:0] OP_OR   = l'(4'h7);
    localparam logic [l-1:0] OP_AND  = l'(4'h8);
    localparam logic [l-1:0] OP_XOR  = l'(4'h9);
    localparam logic [l-1:0] OP_SLL  = l'(4'hA);
    localparam logic [l-1:0] OP_SRL  = l'(4'hB);
    localparam logic [l-1:0] OP_SLT  = l'(4'hC);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] x_q, x_d;      // multiplicand, or dividend shifting into quotient
    logic [PW-1:0] acc_q, acc_d;  // product accumulator, or partial remainder
    logic [n-1:0]  y_q, y_d;      // multiplier, or divisor
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          zero_q, zero_d;
    logic          error_q, error_d;
    logic [n-1:0]  result_q, result_d;
`ifdef ALU_EXEC_HIWORD_EN
    logic [n-1:0]  hi_q, hi_d;
`endif

    logic [n-1:0]  alu_res;
    logic          alu_err;
    logic [CW-1:0] shamt;
    logic [PW-1:0] mul_acc;
    logic [n:0]    rem_sh, rem_diff;
    logic          rem_ge;
    logic [n-1:0]  rem_nxt, quo_nxt;
    logic          is_mul, is_div, last;

    assign shamt  = b[CW-1:0];
    assign is_mul = (ALU_Control == OP_MUL);
    assign is_div = (ALU_Control == OP_DIV);
    assign last   = (cnt_q == CW'(n - 1));

    // One shift-add step and one restoring-division step
    assign mul_acc  = y_q[0] ? (acc_q + x_q) : acc_q;
    assign rem_sh   = {acc_q[n-1:0], x_q[n-1]};
    assign rem_diff = rem_sh - {1'b0, y_q};
    assign rem_ge   = ~rem_diff[n];
    assign rem_nxt  = rem_ge ? rem_diff[n-1:0] : rem_sh[n-1:0];
    assign quo_nxt  = {x_q[n-2:0], rem_ge};

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (ALU_Control)
            OP_ADD, OP_ADDI: alu_res = a + b;
            OP_SUB, OP_SUBI: alu_res = a - b;
            OP_OR:           alu_res = a | b;
            OP_AND:          alu_res = a & b;
            OP_XOR:          alu_res = a ^ b;
            OP_SLL:          alu_res = a << shamt;
            OP_SRL:          alu_res = a >> shamt;
            OP_SLT:          alu_res = n'($signed(a) < $signed(b));
            OP_MUL, OP_DIV:  alu_res = '0;
            default:         alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && is_mul)                 state_d = S_MUL;
                else if (start && is_div && b != '0) state_d = S_DIV;
            end
            S_MUL, S_DIV: if (last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d   = (state_d != S_IDLE);
        done_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        error_d  = error_q;
`ifdef ALU_EXEC_HIWORD_EN
        hi_d     = hi_q;
`endif
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mul || (is_div && b != '0)) begin
                        x_d   = PW'(a);
                        y_d   = b;
                        acc_d = '0;
                        cnt_d = '0;
                    end else if (is_div) begin
                        done_d   = 1'b1;
                        result_d = '1;
                        zero_d   = 1'b0;
                        error_d  = 1'b1;
`ifdef ALU_EXEC_HIWORD_EN
                        hi_d     = a;
`endif
                    end else begin
                        done_d   = 1'b1;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        error_d  = alu_err;
`ifdef ALU_EXEC_HIWORD_EN
                        hi_d     = '0;
`endif
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_acc;
                x_d   = x_q << 1;
                y_d   = y_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    done_d   = 1'b1;
                    result_d = mul_acc[n-1:0];
                    zero_d   = (mul_acc[n-1:0] == '0);
                    error_d  = 1'b0;
`ifdef ALU_EXEC_HIWORD_EN
                    hi_d     = mul_acc[PW-1:n];
`endif
                end
            end
            S_DIV: begin
                acc_d = PW'(rem_nxt);
                x_d   = PW'(quo_nxt);
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    done_d   = 1'b1;
                    result_d = quo_nxt;
                    zero_d   = (quo_nxt == '0);
                    error_d  = 1'b0;
`ifdef ALU_EXEC_HIWORD_EN
                    hi_d     = rem_nxt;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef ALU_EXEC_HIWORD_EN
            hi_q     <= '0;
`endif
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            error_q  <= error_d;
`ifdef ALU_EXEC_HIWORD_EN
            hi_q     <= hi_d;
`endif
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;
    assign error  = error_q;
`ifdef ALU_EXEC_HIWORD_EN
    assign result_hi = hi_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed cases then random ops against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    ALU_Control;
    logic [N-1:0]  a, b;
    logic          busy, done, zero, error;
    logic [N-1:0]  result;
`ifdef ALU_EXEC_HIWORD_EN
    logic [N-1:0]  result_hi;
`endif

    alu_exec_unit dut (
        .clk(clk), .rst(rst), .start(start), .ALU_Control(ALU_Control),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .zero(zero), .error(error)
`ifdef ALU_EXEC_HIWORD_EN
        , .result_hi(result_hi)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] res;
        logic [N-1:0] hi;
        logic         zero;
        logic         err;
        logic         multi;
        int           edge_no;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   ntests = 0;
    int   nfail = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [3:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
        exp_t e;
        logic [2*N-1:0] p;
        e.res = '0; e.hi = '0; e.err = 1'b0; e.multi = 1'b0; e.edge_no = 0;
        case (op)
            4'd1, 4'd3: e.res = x + y;
            4'd2, 4'd4: e.res = x - y;
            4'd5: begin
                p = 64'(x) * 64'(y);
                e.res = p[N-1:0]; e.hi = p[2*N-1:N]; e.multi = 1'b1;
            end
            4'd6: begin
                if (y == 0) begin e.res = '1; e.err = 1'b1; e.hi = x; end
                else begin e.res = x / y; e.hi = x % y; e.multi = 1'b1; end
            end
            4'd7:  e.res = x | y;
            4'd8:  e.res = x & y;
            4'd9:  e.res = x ^ y;
            4'd10: e.res = x << y[4:0];
            4'd11: e.res = x >> y[4:0];
            4'd12: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: e.err = 1'b1;
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Issue one op; for multi-cycle ops, hold off n cycles while scrambling operands and optionally pulsing start
    task automatic issue(input logic [3:0] op, input logic [N-1:0] x, input logic [N-1:0] y, input bit junk);
        exp_t e;
        e = model(op, x, y);
        e.edge_no = cyc + 1 + (e.multi ? N : 0);
        if (e.multi) begin busy_lo = cyc + 1; busy_hi = cyc + N; end
        sb.push_back(e);
        start = 1'b1; ALU_Control = op; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; ALU_Control = 4'($urandom); a = $urandom; b = $urandom;
        if (e.multi) begin
            for (int k = 1; k <= N; k++) begin
                if (junk && k == 5) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0; ALU_Control = 4'($urandom); a = $urandom; b = $urandom;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   N'(busy),   '0);
        check({tag, "_done"},   N'(done),   '0);
        check({tag, "_result"}, result,     '0);
        check({tag, "_zero"},   N'(zero),   '0);
        check({tag, "_error"},  N'(error),  '0);
`ifdef ALU_EXEC_HIWORD_EN
        check({tag, "_hi"},     result_hi,  '0);
`endif
    endtask

    // Monitor: pops the scoreboard on each done and checks busy/hold behaviour every cycle
    logic [N-1:0] last_res = '0;
    logic         last_zero = 1'b0, last_err = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_res = '0; last_zero = 1'b0; last_err = 1'b0;
        end else begin
            check("busy", N'(busy), N'(cyc >= busy_lo && cyc <= busy_hi));
            if (done) begin
                if (sb.size() == 0) begin
                    ntests++; nfail++;
                    $display("FAIL spurious_done cyc=%0d got=1 exp=0", cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", N'(cyc), N'(e.edge_no));
                    check("result", result, e.res);
                    check("zero", N'(zero), N'(e.zero));
                    check("error", N'(error), N'(e.err));
`ifdef ALU_EXEC_HIWORD_EN
                    check("result_hi", result_hi, e.hi);
`endif
                end
                last_res = result; last_zero = zero; last_err = error;
            end else begin
                if (sb.size() != 0 && sb[0].edge_no <= cyc) begin
                    ntests++; nfail++;
                    $display("FAIL missing_done cyc=%0d got=0 exp_cycle=%0d", cyc, sb[0].edge_no);
                    void'(sb.pop_front());
                end
                check("hold_result", result, last_res);
                check("hold_flags", N'({zero, error}), N'({last_zero, last_err}));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]   op;
        logic [N-1:0] x, y;
        rst = 1'b1; start = 1'b0; ALU_Control = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        issue(4'd1, 32'd5, 32'd7, 1'b0);
        issue(4'd2, 32'd3, 32'd3, 1'b0);
        issue(4'd12, 32'hFFFF_FFFF, 32'd1, 1'b0);
        issue(4'd10, 32'd1, 32'd33, 1'b0);
        issue(4'd5, 32'h0001_0000, 32'h0003_0000, 1'b1);
        issue(4'd6, 32'd100, 32'd7, 1'b1);
        issue(4'd6, 32'd123, 32'd0, 1'b0);
        issue(4'd14, 32'd9, 32'd9, 1'b0);
        issue(4'd0, 32'd1, 32'd2, 1'b0);
        issue(4'd11, 32'h8000_0000, 32'd31, 1'b0);
        issue(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(4'd6, 32'd5, 32'd9, 1'b0);

        // Reset in the middle of a divide: abandoned, no done afterwards
        start = 1'b1; ALU_Control = 4'd6; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        busy_lo = cyc; busy_hi = cyc + N - 1;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        busy_lo = 1; busy_hi = 0;
        #1;
        check_reset_outputs("midop_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (N + 4) @(posedge clk);
        #1;
        issue(4'd3, 32'd40, 32'd2, 1'b0);

        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = $urandom;
            y  = $urandom;
            case ($urandom_range(0, 5))
                0: y = '0;
                1: y = 32'($urandom_range(0, 40));
                2: x = y;
                default: ;
            endcase
            issue(op, x, y, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", N'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 4-bit ALU_Control code produced by the ALU decoder.
- Executes the selected operation on two operands and returns a registered result with a done pulse.
- Single-cycle ops complete in 1 cycle. Multiply and divide run as iterative multi-cycle sequences behind a busy/start handshake.
- Sits in the CPU execute stage, between the decoder/register file and writeback; the control FSM stalls on busy.

Parameters:
- n, 32, operand/result width in bits (power of 2, >= 8)
- l, 4, ALU_Control width in bits (must match the decoder)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- ALU_Control  input  l  operation code from the ALU decoder
- a  input  n  operand A (rs)
- b  input  n  operand B (rt or immediate)
- busy  output  1  multi-cycle op in progress; start ignored while high
- done  output  1  one-cycle pulse; result/zero/error valid
- result  output  n  registered result, held until the next done
- zero  output  1  result==0, registered with result
- error  output  1  illegal code or divide-by-zero, registered with result

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, result=0, zero=0, error=0. The internal counter and accumulators are cleared. Reset mid-operation abandons the op; no done is produced.
- Op codes:
  - 0001 and 0011: add.
  - 0010 and 0100: sub (a-b).
  - 0101: mul. 0110: div (unsigned quotient).
  - 0111: or. 1000: and. 1001: xor.
  - 1010: sll by b[log2(n)-1:0]. 1011: srl (logical) by b[log2(n)-1:0].
  - 1100: slt (signed; result 1 or 0).
  - 0000 and 1101-1111: illegal.
- Arithmetic: add/sub/mul wrap modulo 2^n. mul returns the low n bits of the unsigned product. No overflow flag.
- FSM states: IDLE, MUL, DIV.
- IDLE, start=1, single-cycle or illegal code:
  - Compute combinationally and register; done=1 in cycle T+1.
  - Stay in IDLE, so back-to-back starts every cycle are legal.
- IDLE, start=1, code 0101: latch a and b, clear the product accumulator and counter, go to MUL.
- IDLE, start=1, code 0110 with b!=0: latch, clear the remainder, go to DIV.
- IDLE, start=1, code 0110 with b==0: no DIV entry. result all ones, error=1, done=1 in cycle T+1.
- MUL: shift-add, one multiplier bit per cycle, for n cycles.
- DIV: restoring division, one quotient bit per cycle, for n cycles.
- Multi-cycle timing:
  - The counter runs 0..n-1. After the last iteration the FSM returns to IDLE.
  - busy=1 in cycles T+1..T+n; done=1 in cycle T+n+1.
  - A new start may be sampled in cycle T+n+1.
- start while busy=1: ignored entirely. Latched operands are unaffected and nothing is queued.
- Operand changes during MUL/DIV have no effect (operands are latched at T).
- Illegal code: result=0, zero=1, error=1, done pulses in T+1.
- For legal ops error=0.
- done is low in every cycle not listed above.
- result, zero and error change only in a done cycle.

Optional Feature:
- Macro: ALU_EXEC_HIWORD_EN.
- Defined:
  - Adds output port result_hi [n-1:0], registered and updated only with done.
  - Value is the upper n bits of the 2n-bit product for mul, the remainder for div, and 0 otherwise.
  - Divide-by-zero gives result_hi=a. result_hi resets to 0.
- Undefined: the port is absent and no high-word/remainder storage is synthesized. All other timing is identical.

Test Plan:
- Reset, then apply ALU_Control=0001, a=5, b=7, start for one cycle -> done=1 next cycle, result=12, zero=0, error=0, busy never high.
- Back-to-back ops: 0010 with a=3, b=3 -> result=0, zero=1; then 1100 with a=0xFFFFFFFF, b=1 -> result=1; then 1010 with a=1, b=33 -> result=2. Each gives a done pulse the cycle after its start.
- Mul 0101, a=0x00010000, b=0x00030000, start at T -> busy=1 for T+1..T+32, done at T+33, result=0x00000000. With the macro on, result_hi=0x00000003. A start pulsed at T+5 is ignored.
- Div 0110, a=100, b=7 -> done at T+33, result=14, remainder (macro on) result_hi=2. Div with b=0 -> done at T+1, result=0xFFFFFFFF, error=1.
- Illegal code 1110 -> done at T+1, result=0, zero=1, error=1.
- Reset asserted at T+10 of a div -> busy=0 and all outputs 0 immediately; no done follows. A new add after reset completes normally.
